// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
//
// Character-stream front end for the tile screen buffer. Accepts ASCII codes
// over a valid/ready handshake, keeps a text cursor, and drives the buffer
// write port. Printable codes are written at the cursor; LF, CR, BS and FF
// move the cursor, and row-clear / full-screen-clear sweeps are issued as
// multi-cycle write bursts of 0x00. Every output is registered.
//
// Optional feature macro: TEXT_WRITER_TAB_EN
//   defined   : TAB (0x09) jumps to the next multiple of 8, acting as LF when
//               that column falls off the end of the row.
//   undefined : TAB is consumed with no effect.
//
// Ports
//   clk_i      in   pixel clock, the only clock
//   rst_i      in   synchronous active-high reset (restarts the full clear)
//   valid_i    in   char_i holds a character
//   char_i     in   8-bit ASCII code
//   ready_o    out  a character is accepted this cycle if valid_i is high
//   wr_en_o    out  buffer write enable
//   col_w_o    out  buffer write column
//   row_w_o    out  buffer write row
//   din_o      out  buffer write data
//   cur_col_o  out  cursor column (for cursor rendering)
//   cur_row_o  out  cursor row
// ---------------------------------------------------------------------------
module text_writer #(
  parameter int H_TILES        = 175,
  parameter int V_TILES        = 65,
  parameter int NUM_TILES      = H_TILES * V_TILES,
  parameter int ADDR_COL_WIDTH = 8,
  parameter int ADDR_ROW_WIDTH = 7,
  parameter int DATA_WIDTH     = 7
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [7:0]                char_i,
  output logic                      ready_o,
  output logic                      wr_en_o,
  output logic [ADDR_COL_WIDTH-1:0] col_w_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
  output logic [DATA_WIDTH-1:0]     din_o,
  output logic [ADDR_COL_WIDTH-1:0] cur_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cur_row_o
);

  localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(V_TILES - 1);
  localparam logic [ADDR_COL_WIDTH-1:0] COL_ONE  = ADDR_COL_WIDTH'(1);
  localparam logic [ADDR_ROW_WIDTH-1:0] ROW_ONE  = ADDR_ROW_WIDTH'(1);

  // Catch a parameter set whose tile count or limits do not fit the address
  // counters; the compare-and-reset arithmetic relies on both.
  if (NUM_TILES != H_TILES * V_TILES ||
      H_TILES > (1 << ADDR_COL_WIDTH) || V_TILES > (1 << ADDR_ROW_WIDTH)) begin : g_param_check
    $error("text_writer: inconsistent tile geometry parameters");
  end

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_COL_WIDTH-1:0] cur_col_q, cur_col_d;
  logic [ADDR_ROW_WIDTH-1:0] cur_row_q, cur_row_d;
  logic [ADDR_COL_WIDTH-1:0] sw_col_q, sw_col_d;
  logic [ADDR_ROW_WIDTH-1:0] sw_row_q, sw_row_d;
  logic                      ready_q, ready_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_COL_WIDTH-1:0] col_w_q, col_w_d;
  logic [ADDR_ROW_WIDTH-1:0] row_w_q, row_w_d;
  logic [DATA_WIDTH-1:0]     din_q, din_d;

  logic                      is_printable;
  logic [ADDR_ROW_WIDTH-1:0] row_adv;
  logic                      new_line;

  assign is_printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
  // Row advance wraps at the bottom of the screen; there is no scrolling.
  assign row_adv      = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_ONE;

`ifdef TEXT_WRITER_TAB_EN
  // One extra bit so a tab stop past the last column is visible to the compare.
  logic [ADDR_COL_WIDTH:0] tab_col;
  assign tab_col = ({1'b0, cur_col_q} | (ADDR_COL_WIDTH+1)'(7)) + (ADDR_COL_WIDTH+1)'(1);
`endif

  // State, cursor, sweep counters and all outputs live in one register bank.
  // Reset parks the machine at the start of a full-screen clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLR_ALL;
      cur_col_q <= '0;
      cur_row_q <= '0;
      sw_col_q  <= '0;
      sw_row_q  <= '0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      col_w_q   <= '0;
      row_w_q   <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      sw_col_q  <= sw_col_d;
      sw_row_q  <= sw_row_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      col_w_q   <= col_w_d;
      row_w_q   <= row_w_d;
      din_q     <= din_d;
    end
  end

  // Next-state and next-output logic. Sweeps emit one 0x00 write per cycle;
  // in IDLE an accepted character is decoded into at most one write plus a
  // cursor update, and row advances hand over to a row-clear sweep.
  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    sw_col_d  = sw_col_q;
    sw_row_d  = sw_row_q;
    wr_en_d   = 1'b0;
    col_w_d   = '0;
    row_w_d   = '0;
    din_d     = '0;
    new_line  = 1'b0;

    case (state_q)
      CLR_ALL: begin
        wr_en_d = 1'b1;
        col_w_d = sw_col_q;
        row_w_d = sw_row_q;
        if (sw_col_q == COL_LAST) begin
          sw_col_d = '0;
          if (sw_row_q == ROW_LAST) begin
            sw_row_d = '0;
            state_d  = IDLE;
          end else begin
            sw_row_d = sw_row_q + ROW_ONE;
          end
        end else begin
          sw_col_d = sw_col_q + COL_ONE;
        end
      end

      CLR_ROW: begin
        wr_en_d = 1'b1;
        col_w_d = sw_col_q;
        row_w_d = cur_row_q;
        if (sw_col_q == COL_LAST) begin
          sw_col_d = '0;
          state_d  = IDLE;
        end else begin
          sw_col_d = sw_col_q + COL_ONE;
        end
      end

      IDLE: begin
        if (valid_i && ready_q) begin
          if (is_printable) begin
            wr_en_d = 1'b1;
            col_w_d = cur_col_q;
            row_w_d = cur_row_q;
            din_d   = DATA_WIDTH'(char_i[6:0]);
            if (cur_col_q == COL_LAST) begin
              new_line = 1'b1;
            end else begin
              cur_col_d = cur_col_q + COL_ONE;
            end
          end else if (char_i == 8'h0A) begin
            new_line = 1'b1;
          end else if (char_i == 8'h0D) begin
            cur_col_d = '0;
          end else if (char_i == 8'h08) begin
            // Backspace erases in place and never crosses to the previous row.
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - COL_ONE;
              wr_en_d   = 1'b1;
              col_w_d   = cur_col_q - COL_ONE;
              row_w_d   = cur_row_q;
            end
          end else if (char_i == 8'h0C) begin
            cur_col_d = '0;
            cur_row_d = '0;
            sw_col_d  = '0;
            sw_row_d  = '0;
            state_d   = CLR_ALL;
`ifdef TEXT_WRITER_TAB_EN
          end else if (char_i == 8'h09) begin
            if (tab_col >= (ADDR_COL_WIDTH+1)'(H_TILES)) begin
              new_line = 1'b1;
            end else begin
              cur_col_d = tab_col[ADDR_COL_WIDTH-1:0];
            end
`endif
          end

          // Every row advance lands on column 0 and clears the new row.
          if (new_line) begin
            cur_col_d = '0;
            cur_row_d = row_adv;
            sw_col_d  = '0;
            state_d   = CLR_ROW;
          end
        end
      end

      default: begin
        state_d  = CLR_ALL;
        sw_col_d = '0;
        sw_row_d = '0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  assign ready_o   = ready_q;
  assign wr_en_o   = wr_en_q;
  assign col_w_o   = col_w_q;
  assign row_w_o   = row_w_q;
  assign din_o     = din_q;
  assign cur_col_o = cur_col_q;
  assign cur_row_o = cur_row_q;

endmodule

// File: doc/text_writer.md
# text_writer

Character-stream front end for the tile screen buffer. It accepts 8-bit ASCII codes over a valid/ready handshake, maintains a text cursor and drives the buffer's write port (`wr_en`, `col_w`, `row_w`, `din`). It interprets printable and control characters, and runs row-clear and full-screen-clear sweeps as multi-cycle write bursts. It sits between the character source (UART/CPU) and the buffer, in the pixel clock domain.

## Interface
- `H_TILES`, 175, tiles per row
- `V_TILES`, 65, tile rows
- `NUM_TILES`, H_TILES*V_TILES, total tiles
- `ADDR_COL_WIDTH`, 8, column address width
- `ADDR_ROW_WIDTH`, 7, row address width
- `DATA_WIDTH`, 7, buffer data width
- `clk_i`  in  1  122.61 MHz pixel clock; the only clock
- `rst_i`  in  1  reset; synchronous, active-high
- `valid_i`  in  1  `char_i` is valid
- `char_i`  in  8  ASCII code
- `ready_o`  out  1  writer can accept a character this cycle
- `wr_en_o`  out  1  buffer write enable
- `col_w_o`  out  ADDR_COL_WIDTH  write column
- `row_w_o`  out  ADDR_ROW_WIDTH  write row
- `din_o`  out  DATA_WIDTH  write data
- `cur_col_o`  out  ADDR_COL_WIDTH  cursor column, for cursor rendering
- `cur_row_o`  out  ADDR_ROW_WIDTH  cursor row

## Operation
- FSM states:
  - `CLR_ALL`: sweeps all tiles.
  - `IDLE`: accepts characters.
  - `CLR_ROW`: sweeps the current cursor row.
- A character is accepted on a rising edge where `valid_i && ready_o`. `ready_o` is 1 only in `IDLE`.
- Printable, 0x20–0x7E:
  - Write `char_i[6:0]` at the cursor position.
  - Advance the column.
  - At col H_TILES-1, wrap to col 0 and advance the row, then enter `CLR_ROW`.
- Row advance:
  - From row V_TILES-1, the row wraps to 0. There is no scrolling.
  - Every row advance clears the new row.
- LF, 0x0A: col := 0, row advances (with wrap), enter `CLR_ROW`. No character write.
- CR, 0x0D: col := 0. No write.
- BS, 0x08:
  - If col > 0: col := col-1 and write 0x00 at the new position.
  - If col = 0: no effect. BS never moves to the previous row.
- FF, 0x0C: cursor := (0,0), enter `CLR_ALL`.
- All other codes (other controls, 0x7F, ≥0x80) are consumed with no effect.
- Clear sweeps write din 0x00:
  - `CLR_ROW`: cols 0..H_TILES-1 of the cursor row, ascending.
  - `CLR_ALL`: row-major, row 0..V_TILES-1, col 0..H_TILES-1.
- Address arithmetic uses compare-and-reset at the H_TILES-1 and V_TILES-1 limits. Addresses never exceed those limits, even if the counter width allows more.

## Timing
- While `rst_i` is high:
  - State forced to `CLR_ALL` with sweep counter at 0.
  - `ready_o`=0, `wr_en_o`=0, `col_w_o`=0, `row_w_o`=0, `din_o`=0, cursor=(0,0).
- After `rst_i` falls, the first clear write appears after the first edge. `wr_en_o`=1 for NUM_TILES consecutive cycles (11375 by default).
- `ready_o`=1 after the edge that issues the last sweep write.
- Reset asserted mid-sweep or mid-operation restarts the full clear from tile 0.
- All outputs are registered.
- Accepted character at edge N: the write (if any) is visible on outputs after edge N, for exactly one cycle. The cursor updates at edge N.
- No-write characters: `wr_en_o`=0 after edge N.
- Acceptance that enters `CLR_ROW` or `CLR_ALL` at edge N:
  - `ready_o` falls after edge N.
  - Sweep writes occupy edges N+1 … N+H_TILES (row) or N+1 … N+NUM_TILES (all).
  - `ready_o` rises after the last sweep edge.
- Back-to-back printable characters with `valid_i` held sustain one write per cycle.
- `valid_i` high while `ready_o`=0: nothing is accepted, and `char_i` must be held by the source.

## Configuration
- `TEXT_WRITER_TAB_EN` defined:
  - TAB (0x09) sets col to the next multiple of 8, with no write.
  - If that column is ≥ H_TILES, it behaves as LF.
- Not defined: TAB is consumed with no effect.

## Test plan
- Reset, then release → exactly 11375 writes of 0x00, the last at (174,64). `ready_o` rises the next cycle. Cursor is (0,0).
- Send 'A' (0x41), then 'B' → writes 0x41 at (0,0) and 0x42 at (1,0) on consecutive cycles. Cursor ends at (2,0).
- Cursor at (174,3), send 'Z' → 0x5A written at (174,3), then 175 clear writes on row 4. Cursor is (0,4). `ready_o`=0 for 175 cycles.
- Cursor at (10,64), send LF → row 0 is cleared (175 writes). Cursor is (0,0).
- Cursor at (0,5), send BS → no write, cursor unchanged. Cursor at (7,5), send BS → 0x00 written at (6,5).
- With `TEXT_WRITER_TAB_EN`:
  - Cursor (3,2), send TAB → cursor (8,2), no write.
  - Cursor (170,2), send TAB → row 3 cleared, cursor (0,3).
  - Without the macro → cursor unchanged in both cases.
